// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer
//   Accepts pixels from a drawer with no backpressure, drops out-of-bounds
//   coordinates, buffers the rest in a small FIFO and writes them to a
//   framebuffer as linear-address RGB565 words over a req/ack interface.
//   A src_done pulse from the drawer becomes a one-cycle fb_done once every
//   pixel it preceded has been written.
//
// Parameters
//   FB_WIDTH, FB_HEIGHT : visible framebuffer size in pixels
//   FIFO_DEPTH          : pixel buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   pix_valid           : pixel present this cycle
//   pix_x, pix_y        : pixel coordinates
//   pix_color           : RGB888 colour {R, G, B}
//   src_done            : end-of-primitive pulse from the drawer
//   mem_req             : framebuffer write request
//   mem_addr            : linear address py*FB_WIDTH+px
//   mem_wdata           : RGB565 pixel data
//   mem_ack             : write accepted at this edge
//   busy                : FIFO non-empty or write outstanding
//   fb_done             : one-cycle completion pulse
//   overflow            : sticky, an in-bounds pixel was dropped
//   clip_count          : (PIX_CLIP_CNT_EN only) saturating count of
//                         out-of-bounds pixels discarded
//
// Build option
//   PIX_CLIP_CNT_EN     : define to add the clip_count port and counter.

module pixel_fb_writer #(
  parameter int unsigned FB_WIDTH   = 160,
  parameter int unsigned FB_HEIGHT  = 120,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [7:0]  pix_x,
  input  logic [7:0]  pix_y,
  input  logic [23:0] pix_color,
  input  logic        src_done,
  output logic        mem_req,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        fb_done,
  output logic        overflow
`ifdef PIX_CLIP_CNT_EN
  ,
  output logic [15:0] clip_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]  CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [14:0]  WIDTH_15 = 15'(FB_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t state;

  // Pixel front end
  logic        in_bounds;
  logic [14:0] pix_addr;
  logic [15:0] pix_rgb;
  logic        unused_color;

  assign in_bounds = (32'(pix_x) < FB_WIDTH) && (32'(pix_y) < FB_HEIGHT);
  assign pix_addr  = 15'(pix_y) * WIDTH_15 + 15'(pix_x);
  assign pix_rgb   = {pix_color[23:19], pix_color[15:10], pix_color[7:3]};
  // Low colour bits are truncated by the RGB565 packing.
  assign unused_color = ^{pix_color[18:16], pix_color[9:8], pix_color[2:0]};

  // FIFO
  logic [30:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic [30:0]   head;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign head     = fifo_mem[rd_ptr];
  assign push_req = pix_valid && in_bounds;
  // The write register reloads from the FIFO head when idle, or on an ack.
  assign pop      = !empty && ((state == IDLE) || ((state == WRITE) && mem_ack));
  // A full FIFO still accepts a pixel when the same edge frees a slot.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pix_addr, pix_rgb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Write FSM and completion tracking
  logic pending;
  logic drained;

  assign drained = pending && empty && !mem_req;
  assign busy    = !empty || mem_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pending   <= 1'b0;
      fb_done   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            {mem_addr, mem_wdata} <= head;
            mem_req               <= 1'b1;
            state                 <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            if (!empty) begin
              {mem_addr, mem_wdata} <= head;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase

      fb_done <= drained;
      // A fresh src_done wins over the clear so it is never lost.
      if (src_done) begin
        pending <= 1'b1;
      end else if (drained) begin
        pending <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PIX_CLIP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (pix_valid && !in_bounds && (clip_count != '1)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb_pixel_fb_writer
//   Directed bench for pixel_fb_writer with a write scoreboard: expected
//   {addr, RGB565} words are queued as pixels are driven and popped as the
//   DUT completes each acknowledged write. A monitor also checks that an
//   unacknowledged write holds its address and data.

module tb_pixel_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_x = '0;
  logic [7:0]  pix_y = '0;
  logic [23:0] pix_color = '0;
  logic        src_done = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        fb_done;
  logic        overflow;
`ifdef PIX_CLIP_CNT_EN
  logic [15:0] clip_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q [$];

  int cyc = 0;
  int n_writes = 0;
  int fb_cnt = 0;
  int fb_gap = -1;
  int last_ack_edge = 0;
  bit hold_valid = 1'b0;
  logic [14:0] hold_addr = '0;
  logic [15:0] hold_data = '0;

  pixel_fb_writer #(
    .FB_WIDTH  (160),
    .FB_HEIGHT (120),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .src_done  (src_done),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .fb_done   (fb_done),
    .overflow  (overflow)
`ifdef PIX_CLIP_CNT_EN
    ,
    .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int x, input int y, input logic [23:0] c);
    logic [14:0] a;
    a = 15'(y * 160 + x);
    return {1'b0, a, c[23:19], c[15:10], c[7:3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input logic [23:0] c,
                      input bit sd, input bit keep);
    pix_valid = 1'b1;
    pix_x     = 8'(x);
    pix_y     = 8'(y);
    pix_color = c;
    src_done  = sd;
    if (keep) exp_q.push_back(exp_word(x, y, c));
    tick();
    pix_valid = 1'b0;
    src_done  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (3) tick();
  endtask

  function automatic logic [23:0] colour(input int i);
    return {8'(i * 37 + 16), 8'(i * 53 + 8), 8'(i * 71 + 4)};
  endfunction

  // Posedge count; the monitor reads it at the falling edge.
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("hold_addr", 32'(mem_addr), 32'(hold_addr));
        check("hold_data", 32'(mem_wdata), 32'(hold_data));
      end
      if (fb_done) begin
        fb_cnt++;
        fb_gap = cyc - last_ack_edge;
      end
      if (mem_req && mem_ack) begin
        n_writes++;
        // An address never has bit 31 set, so an empty queue cannot match.
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("write", {1'b0, mem_addr, mem_wdata}, exp);
        last_ack_edge = cyc + 1;
      end
      hold_valid = mem_req && !mem_ack;
      hold_addr  = mem_addr;
      hold_data  = mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int f0;

    // Reset state
    repeat (2) tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fb_done", 32'(fb_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Single pixel, ack tied high: latency, address, colour, fb_done
    mem_ack = 1'b1;
    send(3, 2, 24'hFF8040, 1'b0, 1'b1);
    check("lat_edge1_req", 32'(mem_req), 32'd0);
    tick();
    check("lat_edge2_req", 32'(mem_req), 32'd1);
    check("single_addr", 32'(mem_addr), 32'd323);
    check("single_wdata", 32'(mem_wdata), 32'h0000_FC08);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_req_drop", 32'(mem_req), 32'd0);
    f0 = fb_cnt;
    src_done = 1'b1;
    tick();
    src_done = 1'b0;
    check("done_not_yet", 32'(fb_done), 32'd0);
    tick();
    check("done_pulse", 32'(fb_done), 32'd1);
    tick();
    check("done_cleared", 32'(fb_done), 32'd0);
    check("done_count_a", 32'(fb_cnt - f0), 32'd1);

    // Out-of-bounds pixels, then the far corner
    w0 = n_writes;
    send(200, 5, 24'h123456, 1'b0, 1'b0);
    send(5, 130, 24'h654321, 1'b0, 1'b0);
    repeat (3) tick();
    check("clip_no_req", 32'(mem_req), 32'd0);
    check("clip_no_busy", 32'(busy), 32'd0);
    check("clip_overflow", 32'(overflow), 32'd0);
`ifdef PIX_CLIP_CNT_EN
    check("clip_count_2", 32'(clip_count), 32'd2);
`endif
    send(160, 0, 24'hFFFFFF, 1'b0, 1'b0);
    send(0, 120, 24'hFFFFFF, 1'b0, 1'b0);
`ifdef PIX_CLIP_CNT_EN
    tick();
    check("clip_count_4", 32'(clip_count), 32'd4);
`endif
    send(159, 119, 24'hA5C3E7, 1'b0, 1'b1);
    wait_idle("corner_idle", 20);
    check("clip_writes", 32'(n_writes - w0), 32'd1);

    // Overflow: 12 pixels with ack held low
    mem_ack = 1'b0;
    w0 = n_writes;
    for (int i = 0; i < 12; i++) begin
      send(i * 13, i + 1, colour(i), 1'b0, i < 9);
    end
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_no_writes", 32'(n_writes - w0), 32'd0);
    check("ovf_req_held", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    wait_idle("ovf_idle", 40);
    check("ovf_writes", 32'(n_writes - w0), 32'd9);
    check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Ack toggling every other cycle over 5 pixels, src_done on the last
    w0 = n_writes;
    f0 = fb_cnt;
    fb_gap = -1;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i % 2) == 1;
      send(100 + i, 50 + i, colour(i + 20), i == 4, 1'b1);
    end
    for (int i = 0; i < 30; i++) begin
      mem_ack = ~mem_ack;
      tick();
    end
    mem_ack = 1'b1;
    check("tog_writes", 32'(n_writes - w0), 32'd5);
    check("tog_done_count", 32'(fb_cnt - f0), 32'd1);
    check("tog_done_gap", 32'(fb_gap), 32'd1);
    check("tog_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-write with 3 pixels buffered and a src_done pending
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(10 + i, 7, colour(i + 40), i == 3, 1'b1);
    end
    check("mid_req_high", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fb_done", 32'(fb_done), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    w0 = n_writes;
    f0 = fb_cnt;
    repeat (2) tick();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    repeat (10) tick();
    check("mid_no_writes", 32'(n_writes - w0), 32'd0);
    check("mid_no_done", 32'(fb_cnt - f0), 32'd0);
    check("mid_req_low", 32'(mem_req), 32'd0);

    // src_done coincident with the last pixel, ack always high
    w0 = n_writes;
    f0 = fb_cnt;
    fb_gap = -1;
    send(20, 30, colour(60), 1'b0, 1'b1);
    send(21, 30, colour(61), 1'b0, 1'b1);
    send(22, 30, colour(62), 1'b1, 1'b1);
    wait_idle("last_idle", 20);
    check("last_writes", 32'(n_writes - w0), 32'd3);
    check("last_done_count", 32'(fb_cnt - f0), 32'd1);
    check("last_done_gap", 32'(fb_gap), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL provide parameter FB_WIDTH, default 160, visible framebuffer width in pixels.
REQ-002 SHALL provide parameter FB_HEIGHT, default 120, visible framebuffer height in pixels.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 8, pixel buffer entries, power of two, minimum 2.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pix_valid  in  1  pixel present this cycle; no backpressure to the drawer.
REQ-007 SHALL have ports pix_x and pix_y  in  8 each  pixel coordinates.
REQ-008 SHALL have port pix_color  in  24  RGB888 colour: [23:16] R, [15:8] G, [7:0] B.
REQ-009 SHALL have port src_done  in  1  one-cycle pulse marking the end of a drawer primitive.
REQ-010 SHALL have port mem_req  out  1  framebuffer write request.
REQ-011 SHALL have port mem_addr  out  15  linear address, py*FB_WIDTH+px.
REQ-012 SHALL have port mem_wdata  out  16  RGB565 pixel data.
REQ-013 SHALL have port mem_ack  in  1  write accepted at this edge.
REQ-014 SHALL have ports busy  out  1 and fb_done  out  1; busy is FIFO non-empty or mem_req high; fb_done is a one-cycle completion pulse.
REQ-015 SHALL have port overflow  out  1  sticky flag for a dropped in-bounds pixel.

Function
REQ-016 SHALL discard any pixel with pix_x>=FB_WIDTH or pix_y>=FB_HEIGHT before the FIFO, with no effect on overflow.
REQ-017 SHALL push each in-bounds valid pixel into the FIFO at the sampling edge, storing its address and {R[7:3],G[7:2],B[7:3]}.
REQ-018 SHALL accept a push while full only if a pop occurs on the same edge; otherwise it SHALL drop the pixel and set overflow.
REQ-019 SHALL use FSM states IDLE and WRITE: IDLE with FIFO non-empty pops the head into mem_addr/mem_wdata, raises mem_req, and moves to WRITE.
REQ-020 SHALL, in WRITE, hold mem_req, mem_addr and mem_wdata stable until mem_ack is sampled high.
REQ-021 SHALL, on an ack edge, pop the next entry and keep mem_req high if the FIFO is non-empty (back-to-back, one write per cycle); otherwise it SHALL drop mem_req and return to IDLE.
REQ-022 SHALL give a latency of two edges from sampling pix_valid to mem_req high when the FIFO is empty and the FSM is in IDLE.
REQ-023 SHALL ignore mem_ack while mem_req is low.
REQ-024 SHALL preserve write order exactly in pixel arrival order.
REQ-025 SHALL, on src_done, set a pending flag; fb_done SHALL pulse for one cycle on the first edge where pending is set, the FIFO is empty and mem_req is low, and that edge SHALL clear pending.
REQ-026 SHALL, when src_done and pix_valid coincide, push the pixel first, so that fb_done follows that pixel's ack.
REQ-027 SHALL pulse fb_done exactly once for a src_done that arrives while idle with nothing pending, on the next edge.

Reset
REQ-028 SHALL, with rst_n low, immediately force mem_req=0, mem_addr=0, mem_wdata=0, fb_done=0, busy=0, overflow=0, FIFO empty, pending=0 and FSM=IDLE.
REQ-029 SHALL, when reset is asserted mid-write, abandon the outstanding write and discard all buffered pixels.
REQ-030 SHALL act on pixels sampled from the first edge after rst_n rises.

Configuration
REQ-031 SHALL, with PIX_CLIP_CNT_EN defined, add output clip_count  out  16, counting pixels discarded by REQ-016, saturating at 16'hFFFF, reset to 0.
REQ-032 SHALL, with PIX_CLIP_CNT_EN undefined, have no clip_count port and no counter logic, with all other behaviour identical.

Verification
REQ-033 SHALL verify: pixel (3,2) colour 24'hFF8040, mem_ack tied high -> mem_req after 2 edges, mem_addr=323, mem_wdata=16'hFC08, then fb_done after src_done.
REQ-034 SHALL verify: pixel (200,5) then (5,130) -> no mem_req, overflow=0, clip_count=2 when PIX_CLIP_CNT_EN is defined.
REQ-035 SHALL verify: 12 consecutive in-bounds pixels with mem_ack held low -> 9 pixels retained (8 in the FIFO plus 1 in the WRITE register), overflow=1, and after releasing ack exactly 9 writes in order.
REQ-036 SHALL verify: mem_ack toggling every other cycle over 5 pixels -> mem_addr/mem_wdata stable while unacked, 5 ordered writes, fb_done once after the last ack.
REQ-037 SHALL verify: rst_n pulsed low while mem_req is high with 3 pixels buffered -> all outputs 0 at once, no further writes after release.
REQ-038 SHALL verify: src_done coincident with the last pixel, ack always high -> fb_done exactly one cycle after that pixel's ack edge.
